// File: rtl/dilithium_pkg.sv
// Shared constants and state encoding for the SHAKE-256 request arbiter.
// Imported by the arbiter top so widths and the timeout default stay in one place.
package dilithium_pkg;

  localparam int SEED_W          = 256;
  localparam int DATA_W          = 1024;
  localparam int CNT_W           = 16;
  localparam int TIMEOUT_DEFAULT = 4095;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_DELIVER = 3'd4,
    S_ABORT   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/shake_rr_pick.sv
// Two-way round-robin requester selection; the pointer only matters under contention.
module shake_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  output logic o_owner,
  output logic o_any
);

  logic w_both;

  assign w_both  = i_req0 & i_req1;
  assign o_any   = i_req0 | i_req1;
  assign o_owner = w_both ? i_ptr : i_req1;

endmodule

// File: rtl/shake256_arbiter.sv
// Shares one SHAKE-256 core between two requesters: grant, start, wait for done
// (with stale-done filtering and timeout), then deliver the result or abort.
module shake256_arbiter
  import dilithium_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [SEED_W-1:0] i_seed0,
  input  logic [SEED_W-1:0] i_seed1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_valid0,
  output logic              o_valid1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_busy,
  output logic              o_core_start,
  output logic [SEED_W-1:0] o_core_seed,
  output logic              o_core_reset,
  input  logic [DATA_W-1:0] i_core_data,
  input  logic              i_core_done
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        r_state;
  logic              r_ptr;
  logic              r_owner;
  logic [SEED_W-1:0] r_seed;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_seen_low;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_valid0;
  logic              r_valid1;
  logic              r_err0;
  logic              r_err1;
  logic              r_busy;
  logic              r_start;
  logic              r_abort;

  logic w_owner;
  logic w_any;

  shake_rr_pick u_pick (
    .i_req0  (i_req0),
    .i_req1  (i_req1),
    .i_ptr   (r_ptr),
    .o_owner (w_owner),
    .o_any   (w_any)
  );

  // Outputs are registered alongside the state they belong to, so each pulse
  // lines up exactly with the cycle spent in GRANT, START, DELIVER or ABORT.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_seed     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_seen_low <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_start  <= 1'b0;
      r_abort  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_owner <= w_owner;
            r_seed  <= w_owner ? i_seed1 : i_seed0;
            r_gnt0  <= ~w_owner;
            r_gnt1  <= w_owner;
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          r_state <= S_START;
          r_start <= 1'b1;
        end
        S_START: begin
          r_state    <= S_WAIT;
          r_cnt      <= '0;
          r_seen_low <= 1'b0;
        end
        // A done that was already high when WAIT began belongs to the previous job.
        S_WAIT: begin
          if (i_core_done && r_seen_low) begin
            r_state  <= S_DELIVER;
            r_data   <= i_core_data;
            r_valid0 <= ~r_owner;
            r_valid1 <= r_owner;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state <= S_ABORT;
            r_cnt   <= r_cnt + 1'b1;
            r_err0  <= ~r_owner;
            r_err1  <= r_owner;
            r_abort <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!i_core_done) begin
              r_seen_low <= 1'b1;
            end
          end
        end
        S_DELIVER, S_ABORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= ~r_owner;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt0       = r_gnt0;
  assign o_gnt1       = r_gnt1;
  assign o_valid0     = r_valid0;
  assign o_valid1     = r_valid1;
  assign o_err0       = r_err0;
  assign o_err1       = r_err1;
  assign o_data_out   = r_data;
  assign o_busy       = r_busy;
  assign o_core_start = r_start;
  assign o_core_seed  = r_seed;
  assign o_core_reset = i_reset | r_abort;

endmodule

// File: tb/tb_shake256_arbiter.sv
// Directed and randomized checks of shake256_arbiter against a transaction-level
// model: arbitration order, latency, stale-done filtering, timeout and reset.
module tb_shake256_arbiter;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0;
  logic          req1;
  logic [255:0]  seed0;
  logic [255:0]  seed1;
  logic [1023:0] coreData;
  logic          coreDone;

  logic          mGnt0, mGnt1, mValid0, mValid1, mErr0, mErr1, mBusy, mStart, mCoreReset;
  logic [1023:0] mData;
  logic [255:0]  mSeed;
  logic          tGnt0, tGnt1, tValid0, tValid1, tErr0, tErr1, tBusy, tStart, tCoreReset;
  logic [1023:0] tData;
  logic [255:0]  tSeed;

  bit            useT;
  logic          obsGnt0, obsGnt1, obsValid0, obsValid1, obsErr0, obsErr1, obsBusy, obsStart, obsCoreReset;
  logic [1023:0] obsData;
  logic [255:0]  obsSeed;

  int errCount   = 0;
  int checkCount = 0;
  bit modelPtr;

  always #5 clock = ~clock;

  shake256_arbiter u_dut (
    .i_clock(clock), .i_reset(reset), .i_req0(req0), .i_req1(req1),
    .i_seed0(seed0), .i_seed1(seed1),
    .o_gnt0(mGnt0), .o_gnt1(mGnt1), .o_valid0(mValid0), .o_valid1(mValid1),
    .o_err0(mErr0), .o_err1(mErr1), .o_data_out(mData), .o_busy(mBusy),
    .o_core_start(mStart), .o_core_seed(mSeed), .o_core_reset(mCoreReset),
    .i_core_data(coreData), .i_core_done(coreDone)
  );

  shake256_arbiter #(.TIMEOUT_CYCLES(8)) u_dutT (
    .i_clock(clock), .i_reset(reset), .i_req0(req0), .i_req1(req1),
    .i_seed0(seed0), .i_seed1(seed1),
    .o_gnt0(tGnt0), .o_gnt1(tGnt1), .o_valid0(tValid0), .o_valid1(tValid1),
    .o_err0(tErr0), .o_err1(tErr1), .o_data_out(tData), .o_busy(tBusy),
    .o_core_start(tStart), .o_core_seed(tSeed), .o_core_reset(tCoreReset),
    .i_core_data(coreData), .i_core_done(coreDone)
  );

  // Both instances see the same stimulus; useT picks which one is being judged.
  assign obsGnt0      = useT ? tGnt0      : mGnt0;
  assign obsGnt1      = useT ? tGnt1      : mGnt1;
  assign obsValid0    = useT ? tValid0    : mValid0;
  assign obsValid1    = useT ? tValid1    : mValid1;
  assign obsErr0      = useT ? tErr0      : mErr0;
  assign obsErr1      = useT ? tErr1      : mErr1;
  assign obsBusy      = useT ? tBusy      : mBusy;
  assign obsStart     = useT ? tStart     : mStart;
  assign obsCoreReset = useT ? tCoreReset : mCoreReset;
  assign obsData      = useT ? tData      : mData;
  assign obsSeed      = useT ? tSeed      : mSeed;

  task automatic checkOutput(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s observed(low128)=%h expected(low128)=%h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    checkOutput("one_pulse", 1024'($countones({obsGnt0, obsGnt1, obsValid0, obsValid1, obsErr0, obsErr1}) <= 1), 1);
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [255:0] s0, input logic [255:0] s1);
    req0  = r0;
    req1  = r1;
    seed0 = s0;
    seed1 = s1;
  endtask

  function automatic logic [1023:0] randData();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] randSeed();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic anyPulse();
    return obsGnt0 | obsGnt1 | obsValid0 | obsValid1 | obsErr0 | obsErr1 | obsCoreReset;
  endfunction

  task automatic checkResetState();
    checkOutput("rst_busy", obsBusy, 0);
    checkOutput("rst_gnt", {obsGnt0, obsGnt1}, 0);
    checkOutput("rst_valid", {obsValid0, obsValid1}, 0);
    checkOutput("rst_err", {obsErr0, obsErr1}, 0);
    checkOutput("rst_core_start", obsStart, 0);
    checkOutput("rst_data_out", obsData, 0);
    checkOutput("rst_core_seed", obsSeed, 0);
    checkOutput("rst_core_reset", obsCoreReset, 1);
  endtask

  // One complete job; called right after an edge with the request(s) already driven.
  task automatic serveJob(input bit expOwner, input logic [255:0] expSeed, input int delay,
                          input int staleHold, input int raiseOtherAt,
                          input logic [1023:0] dat, input logic [255:0] otherSeed);
    logic saw;
    tick();
    checkOutput("gnt_owner", expOwner ? obsGnt1 : obsGnt0, 1);
    checkOutput("gnt_other", expOwner ? obsGnt0 : obsGnt1, 0);
    checkOutput("busy_in_job", obsBusy, 1);
    if (expOwner) req1 = 1'b0; else req0 = 1'b0;
    tick();
    checkOutput("core_start", obsStart, 1);
    checkOutput("core_seed", obsSeed, expSeed);
    saw = 1'b0;
    if (staleHold == 0) coreDone = 1'b0;
    for (int k = 0; k < staleHold; k++) begin
      tick();
      saw = saw | anyPulse();
    end
    coreDone = 1'b0;
    for (int k = 0; k < delay; k++) begin
      if (k == raiseOtherAt) begin
        if (expOwner) begin req0 = 1'b1; seed0 = otherSeed; end
        else begin req1 = 1'b1; seed1 = otherSeed; end
      end
      tick();
      saw = saw | anyPulse();
    end
    checkOutput("quiet_in_wait", saw, 0);
    coreDone = 1'b1;
    coreData = dat;
    tick();
    checkOutput("valid_owner", expOwner ? obsValid1 : obsValid0, 1);
    checkOutput("valid_other", expOwner ? obsValid0 : obsValid1, 0);
    checkOutput("gnt_held_off", {obsGnt0, obsGnt1}, 0);
    checkOutput("data_out", obsData, dat);
    tick();
    checkOutput("busy_after", obsBusy, 0);
    checkOutput("valid_done", {obsValid0, obsValid1}, 0);
    modelPtr = ~expOwner;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1023:0] dA;
    logic [255:0]  sA;
    logic [255:0]  sB;
    logic          saw;
    bit            expOwner;
    int            pat;

    useT = 1'b0;
    reset = 1'b1;
    applyStimulus(0, 0, '0, '0);
    coreDone = 1'b0;
    coreData = '0;
    modelPtr = 1'b0;
    repeat (3) tick();
    checkResetState();

    // Single request with a zero seed, done 24 cycles after start.
    reset = 1'b0;
    applyStimulus(1, 0, 256'h0, '0);
    serveJob(0, 256'h0, 24, 0, -1, randData(), '0);

    // Done still high from the last job must not complete the next one early.
    sA = randSeed();
    applyStimulus(1, 0, sA, '0);
    serveJob(0, sA, 5, 4, -1, randData(), '0);

    // req1 raised mid-job is held off, then served from IDLE.
    sA = randSeed();
    sB = randSeed();
    applyStimulus(1, 0, sA, '0);
    serveJob(0, sA, 10, 0, 3, randData(), sB);
    serveJob(1, sB, 6, 0, -1, randData(), '0);

    // Contention straight after reset: pointer 0 wins first.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sA = randSeed();
    applyStimulus(1, 1, sA, {32{8'hAA}});
    modelPtr = 1'b0;
    serveJob(0, sA, 4, 0, -1, randData(), '0);
    serveJob(1, {32{8'hAA}}, 4, 0, -1, randData(), '0);

    // Reset while waiting abandons the job silently.
    applyStimulus(1, 0, randSeed(), '0);
    coreDone = 1'b0;
    tick();
    tick();
    req0 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkResetState();
    reset = 1'b0;
    coreDone = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      tick();
      saw = saw | anyPulse();
    end
    checkOutput("no_pulse_after_reset", saw, 0);
    checkOutput("idle_after_reset", obsBusy, 0);
    modelPtr = 1'b0;

    // Random request patterns; a losing requester keeps its request up.
    for (int n = 0; n < 12; n++) begin
      if (!req0 && !req1) begin
        pat = $urandom_range(1, 3);
        req0 = pat[0];
        req1 = pat[1];
        if (req0) seed0 = randSeed();
        if (req1) seed1 = randSeed();
      end
      expOwner = (req0 && req1) ? modelPtr : req1;
      serveJob(expOwner, expOwner ? seed1 : seed0, $urandom_range(2, 12),
               $urandom_range(0, 3), -1, randData(), '0);
    end

    // Timeout behaviour on the instance configured for 8 wait cycles.
    useT = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelPtr = 1'b0;
    dA = randData();
    applyStimulus(1, 0, randSeed(), '0);
    serveJob(0, seed0, 3, 0, -1, dA, '0);

    sA = randSeed();
    sB = randSeed();
    applyStimulus(1, 1, sA, sB);
    tick();
    checkOutput("to_gnt1_by_ptr", {obsGnt0, obsGnt1}, 2'b01);
    req1 = 1'b0;
    tick();
    checkOutput("to_core_seed", obsSeed, sB);
    coreDone = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      tick();
      saw = saw | anyPulse();
    end
    checkOutput("to_quiet_8", saw, 0);
    tick();
    checkOutput("to_err1", obsErr1, 1);
    checkOutput("to_err0", obsErr0, 0);
    checkOutput("to_core_reset", obsCoreReset, 1);
    checkOutput("to_no_valid", {obsValid0, obsValid1}, 0);
    checkOutput("to_data_kept", obsData, dA);
    tick();
    checkOutput("to_err_cleared", {obsErr0, obsErr1, obsCoreReset}, 0);
    checkOutput("to_idle", obsBusy, 0);
    modelPtr = 1'b0;

    // Pointer flipped back to 0 by the abort, so requester 0 wins now.
    req1 = 1'b1;
    seed1 = randSeed();
    serveJob(0, sA, 3, 0, -1, randData(), '0);
    req1 = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
